axi_slave_rresp_pop_fsm: RTL
============================

Name: axi_slave_rresp_pop_fsm

Overview:
- Drain side of the AXI slave read-response path, the counterpart to the Push FSM that fills the response buffers.
- Pops one burst descriptor (ID, length, error flag) from the descriptor FIFO, then pops exactly ARLEN+1 data beats from the data FIFO.
- Drives those beats onto the AXI R channel with correct RID/RRESP/RLAST under RREADY backpressure.
- Beat tracking uses an internal loadable down-counter (Load/Load_Count/Mode=1/En/Done semantics, as in the shared up/down counter).

Parameters:
- DATA_WIDTH, 64, RDATA and data FIFO word width
- ID_WIDTH, 4, RID and descriptor ID width
- LEN_WIDTH, 8, AXI burst length field width (beats-1)

Ports:
- ACLK  in  1  clock
- ARESETn  in  1  synchronous active-low reset
- desc_empty  in  1  descriptor FIFO empty (FWFT: head valid when 0)
- desc_id  in  ID_WIDTH  head descriptor ID
- desc_len  in  LEN_WIDTH  head descriptor length (beats-1)
- desc_err  in  1  head descriptor error flag
- desc_rd  out  1  descriptor pop strobe, one cycle
- data_empty  in  1  data FIFO empty (FWFT)
- data_in  in  DATA_WIDTH  head data word
- data_rd  out  1  data pop strobe
- RID  out  ID_WIDTH  AXI read ID
- RDATA  out  DATA_WIDTH  AXI read data
- RRESP  out  2  AXI read response
- RLAST  out  1  last beat of burst
- RVALID  out  1  AXI read valid
- RREADY  in  1  AXI read ready
- busy  out  1  burst in progress or RVALID held

Behaviour:
- Single clock ACLK; reset synchronous, active-low (ARESETn sampled at ACLK rising edge).
- Reset values: state=IDLE; RVALID, RLAST, desc_rd, data_rd, busy=0; RID, RDATA, RRESP=0; counter=0.
- Reset mid-burst discards the burst. No FIFO pops occur in the reset cycle.
- States: IDLE, STREAM.
- IDLE:
  - If desc_empty=0: combinational desc_rd=1; capture desc_id/desc_len/desc_err; load counter with desc_len; go STREAM.
  - Otherwise remain in IDLE.
- STREAM, output register load condition: load_ok = (!RVALID || RREADY) && !data_empty.
  - On load_ok: data_rd=1 (combinational); register RDATA<=data_in, RID<=captured ID, RRESP<=err?2'b10:2'b00, RLAST<=counter Done (count==0), RVALID<=1.
  - If count!=0: decrement, stay in STREAM. If count==0: go IDLE.
- Output hold:
  - RVALID=1 && RREADY=0: RID/RDATA/RRESP/RLAST stable, no pop.
  - RVALID=1 && RREADY=1 && no load: RVALID<=0 next cycle.
- Latency: descriptor available at cycle N -> desc_rd at N -> first RVALID at N+2 (assuming data present).
- Throughput: steady state one beat per cycle within a burst. One bubble cycle between bursts (IDLE descriptor fetch).
- The last beat may still be held in the output register while IDLE fetches the next descriptor. RID/RRESP are per-beat registered, so the held beat is never corrupted.
- data_empty mid-burst: stall with no pop. RVALID drops after the pending beat handshakes and resumes when data arrives. Count is unchanged during the stall.
- desc_len=0: single beat with RLAST=1.
- desc_len=255: 256 beats, RLAST only on beat 256. No counter wrap; decrement is never issued at 0.
- Error bursts still pop all len+1 data beats (keeps FIFOs aligned); RRESP=SLVERR on every beat.
- busy = (state==STREAM) || RVALID.
- desc_rd and data_rd are never asserted in the same cycle.

Optional Feature:
- Macro: RRESP_POP_STATUS_EN.
- Defined: adds outputs bursts_done (16-bit) and beats_done (16-bit). Both reset to 0 and wrap at 0xFFFF.
  - beats_done increments on each RVALID&&RREADY.
  - bursts_done increments on each RVALID&&RREADY&&RLAST.
- Undefined: those ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Descriptor {id=3,len=3,err=0} plus 4 data words A0..A3, RREADY=1 -> RVALID N+2..N+5, RDATA A0..A3, RID=3, RRESP=0, RLAST only on A3, 4 data_rd pulses.
- Same burst with RREADY low for 3 cycles at beat 2 -> RDATA=A1 held stable, no data_rd during stall, remaining beats correct, total pops=4.
- Back-to-back descriptors {id=1,len=0} and {id=2,len=1,err=1} -> beat1 RID=1 RLAST=1 RRESP=0; then RID=2 RRESP=2'b10 on both beats, RLAST on second; one bubble between bursts.
- len=255 with continuous data -> 256 beats, RLAST only on beat 256, state returns to IDLE, busy falls after final handshake.
- data_empty=1 for 5 cycles after beat 1 of a len=2 burst -> RVALID low during the gap, count preserved, beats 2..3 delivered, RLAST on beat 3.
- ARESETn=0 asserted mid-burst (beat 2 of 4) -> next cycle RVALID=0, busy=0, state IDLE, no pops; a new descriptor after release is served normally.

Source files
------------

// File: rtl/axi_slave_rresp_pop_fsm_if.sv
// Bundle of descriptor FIFO, data FIFO and AXI R-channel signals for the read-response pop FSM.
// Status outputs exist only when RRESP_POP_STATUS_EN is defined.
interface axi_slave_rresp_pop_fsm_if #(
    parameter int DATA_WIDTH = 64,
    parameter int ID_WIDTH   = 4,
    parameter int LEN_WIDTH  = 8
);
    logic                  desc_empty;
    logic [ID_WIDTH-1:0]   desc_id;
    logic [LEN_WIDTH-1:0]  desc_len;
    logic                  desc_err;
    logic                  desc_rd;
    logic                  data_empty;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  data_rd;
    logic [ID_WIDTH-1:0]   RID;
    logic [DATA_WIDTH-1:0] RDATA;
    logic [1:0]            RRESP;
    logic                  RLAST;
    logic                  RVALID;
    logic                  RREADY;
    logic                  busy;
`ifdef RRESP_POP_STATUS_EN
    logic [15:0]           bursts_done;
    logic [15:0]           beats_done;
`endif

    modport slave (
        input  desc_empty, desc_id, desc_len, desc_err, data_empty, data_in, RREADY,
        output desc_rd, data_rd, RID, RDATA, RRESP, RLAST, RVALID, busy
`ifdef RRESP_POP_STATUS_EN
        , output bursts_done, beats_done
`endif
    );

    modport master (
        output desc_empty, desc_id, desc_len, desc_err, data_empty, data_in, RREADY,
        input  desc_rd, data_rd, RID, RDATA, RRESP, RLAST, RVALID, busy
`ifdef RRESP_POP_STATUS_EN
        , input bursts_done, beats_done
`endif
    );
endinterface

// File: rtl/axi_slave_rresp_pop_fsm.sv
// Drain side of the AXI slave read-response path: pops a burst descriptor, then ARLEN+1 data beats onto R.
// Optional beat/burst status counters are enabled with the RRESP_POP_STATUS_EN macro.
module axi_slave_rresp_pop_fsm #(
    parameter int DATA_WIDTH = 64,
    parameter int ID_WIDTH   = 4,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                         ACLK,
    input  logic                         ARESETn,
    axi_slave_rresp_pop_fsm_if.slave     bus
);
    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] STREAM = 1'b1;

    logic [0:0]            state_q, state_d;
    logic [ID_WIDTH-1:0]   id_q, id_d;
    logic                  err_q, err_d;
    logic [LEN_WIDTH-1:0]  count_q, count_d;
    logic [ID_WIDTH-1:0]   rid_q, rid_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [1:0]            rresp_q, rresp_d;
    logic                  rlast_q, rlast_d;
    logic                  rvalid_q, rvalid_d;

    logic cnt_load, cnt_en, cnt_done;
    logic desc_pop, load_ok;

    // Pops are gated by reset so nothing leaves either FIFO in a reset cycle.
    always_comb begin
        cnt_done = (count_q == '0);
        desc_pop = ARESETn && (state_q == IDLE) && !bus.desc_empty;
        load_ok  = ARESETn && (state_q == STREAM) && (!rvalid_q || bus.RREADY) && !bus.data_empty;
        cnt_load = desc_pop;
        cnt_en   = load_ok && !cnt_done;
    end

    // Beat counter: loads beats-1, counts down, and never decrements past zero.
    always_comb begin
        count_d = count_q;
        if (cnt_load) begin
            count_d = bus.desc_len;
        end else if (cnt_en) begin
            count_d = count_q - 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (desc_pop) begin
                    state_d = STREAM;
                    id_d    = bus.desc_id;
                    err_d   = bus.desc_err;
                end
            end
            STREAM: begin
                if (load_ok && cnt_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // RID/RRESP travel with each beat so a held last beat survives the next descriptor fetch.
    always_comb begin
        rid_d    = rid_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        rlast_d  = rlast_q;
        rvalid_d = rvalid_q;
        if (load_ok) begin
            rdata_d  = bus.data_in;
            rid_d    = id_q;
            rresp_d  = err_q ? 2'b10 : 2'b00;
            rlast_d  = cnt_done;
            rvalid_d = 1'b1;
        end else if (rvalid_q && bus.RREADY) begin
            rvalid_d = 1'b0;
        end
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            state_q  <= IDLE;
            id_q     <= '0;
            err_q    <= 1'b0;
            count_q  <= '0;
            rid_q    <= '0;
            rdata_q  <= '0;
            rresp_q  <= 2'b00;
            rlast_q  <= 1'b0;
            rvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            id_q     <= id_d;
            err_q    <= err_d;
            count_q  <= count_d;
            rid_q    <= rid_d;
            rdata_q  <= rdata_d;
            rresp_q  <= rresp_d;
            rlast_q  <= rlast_d;
            rvalid_q <= rvalid_d;
        end
    end

    assign bus.desc_rd = desc_pop;
    assign bus.data_rd = load_ok;
    assign bus.RID     = rid_q;
    assign bus.RDATA   = rdata_q;
    assign bus.RRESP   = rresp_q;
    assign bus.RLAST   = rlast_q;
    assign bus.RVALID  = rvalid_q;
    assign bus.busy    = (state_q == STREAM) || rvalid_q;

`ifdef RRESP_POP_STATUS_EN
    logic [15:0] beats_q, bursts_q;
    logic        handshake;

    assign handshake = rvalid_q && bus.RREADY;

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            beats_q  <= '0;
            bursts_q <= '0;
        end else if (handshake) begin
            beats_q <= beats_q + 16'd1;
            if (rlast_q) begin
                bursts_q <= bursts_q + 16'd1;
            end
        end
    end

    assign bus.beats_done  = beats_q;
    assign bus.bursts_done = bursts_q;
`endif
endmodule
